// File: rtl/scbuf_rdata_serializer.sv
// Buffers 624-bit c7 read lines (2 entries) and emits each as 4 x 156-bit beats; SCBUF_RDATA_PAR_EN adds per-word beat parity.
// Latency: line pushed at edge N is presented as beat 0 from cycle N+1; vld is purely registered.
// Backpressure: beats hold until cpx_scbuf_rdy; c7 cannot stall, so full is flagged and pushes into a full buffer set sticky ovfl.
module scbuf_rdata_serializer #(
  parameter int WORD_W     = 39,
  parameter int LINE_WORDS = 16,
  parameter int BEAT_WORDS = 4,
  parameter int DEPTH      = 2
) (
  input  logic                                       rclk,
  input  logic                                       arst_l,
  input  logic [WORD_W*LINE_WORDS-1:0]               scdata_scbuf_decc_out_c7,
  input  logic                                       sctag_scbuf_rdvld_c7,
  input  logic                                       cpx_scbuf_rdy,
  output logic [WORD_W*BEAT_WORDS-1:0]               scbuf_rdata_beat,
  output logic                                       scbuf_rdata_vld,
  output logic [$clog2(LINE_WORDS/BEAT_WORDS)-1:0]   scbuf_rdata_beat_id,
  output logic                                       scbuf_rdata_last,
  output logic                                       scbuf_sctag_rd_full,
  output logic                                       scbuf_rdata_ovfl
`ifdef SCBUF_RDATA_PAR_EN
  ,
  output logic [BEAT_WORDS-1:0]                      scbuf_rdata_par
`endif
);

  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int BEAT_W = WORD_W * BEAT_WORDS;
  localparam int BEATS  = LINE_WORDS / BEAT_WORDS;
  localparam int BCW    = $clog2(BEATS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [LINE_W-1:0]             mem [DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              count;
  logic [BCW-1:0]                beat_cnt;
  logic                          ovfl;
  logic [BEATS-1:0][BEAT_W-1:0]  head_beats;
  logic                          xfer, pop, push_ok;

  assign scbuf_rdata_vld     = (count != '0);
  assign scbuf_sctag_rd_full = (count == CNT_W'(DEPTH));
  assign scbuf_rdata_beat_id = beat_cnt;
  assign scbuf_rdata_last    = scbuf_rdata_vld && (beat_cnt == BCW'(BEATS - 1));
  assign scbuf_rdata_ovfl    = ovfl;

  assign xfer    = scbuf_rdata_vld && cpx_scbuf_rdy;
  assign pop     = xfer && (beat_cnt == BCW'(BEATS - 1));
  // A push into a full buffer still lands when the head line retires this edge.
  assign push_ok = sctag_scbuf_rdvld_c7 && ((count < CNT_W'(DEPTH)) || pop);

  assign head_beats       = mem[rd_ptr];
  assign scbuf_rdata_beat = scbuf_rdata_vld ? head_beats[beat_cnt] : '0;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
      ovfl     <= 1'b0;
    end else begin
      if (xfer)
        beat_cnt <= pop ? '0 : beat_cnt + BCW'(1);
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push_ok)
        count <= count - CNT_W'(1);
      if (sctag_scbuf_rdvld_c7 && !push_ok)
        ovfl <= 1'b1;
    end
  end

  // Line storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge rclk) begin
    if (push_ok)
      mem[wr_ptr] <= scdata_scbuf_decc_out_c7;
  end

`ifdef SCBUF_RDATA_PAR_EN
  logic [BEAT_WORDS-1:0][WORD_W-1:0] beat_words;
  assign beat_words = scbuf_rdata_beat;

  always_comb begin
    scbuf_rdata_par = '0;
    for (int i = 0; i < BEAT_WORDS; i++)
      scbuf_rdata_par[i] = ^beat_words[i];
  end
`endif

endmodule
